// File: rtl/uart_rx_core.sv
// UART receive engine: synchronised input, mid-bit start validation, oversampled
// data/parity/stop sampling, one-cycle valid pulse per completed frame.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMPLE_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST   = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state, next_state;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [BW-1:0]          baud_cnt;
    logic [SW-1:0]          sample_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   armed, par_q, stop_err_q;
    logic                   tick, mid_start, bit_end;
    logic                   start_det, restart, finish;
    logic                   par_xor, par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], serial_in};
    end

    assign rx_s      = sync_q[1];
    assign tick      = (baud_cnt == BAUD_LAST);
    assign mid_start = tick && (sample_cnt == SAMPLE_HALF);
    assign bit_end   = tick && (sample_cnt == SAMPLE_LAST);
    assign busy      = (state != S_IDLE);
    assign par_xor   = (^shift_q) ^ rx_s;
    assign par_bad   = (PARITY == 1) ? ~par_xor : par_xor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_det  = 1'b0;
        restart    = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    next_state = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (mid_start) begin
                    if (!rx_s) begin
                        next_state = S_DATA;
                        restart    = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bit_end && bit_cnt == DATA_LAST)
                    next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) next_state = S_STOP;
            end
            S_STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) begin
                    next_state = S_IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Both timing counters sit at zero in IDLE so a start edge always begins a clean bit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt   <= '0;
            sample_cnt <= '0;
        end else if (state == S_IDLE || restart) begin
            baud_cnt   <= '0;
            sample_cnt <= '0;
        end else if (tick) begin
            baud_cnt   <= '0;
            sample_cnt <= (sample_cnt == SAMPLE_LAST) ? '0 : sample_cnt + SW'(1);
        end else begin
            baud_cnt   <= baud_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == S_IDLE && rx_s) armed <= 1'b1;
            if (start_det) begin
                bit_cnt    <= '0;
                par_q      <= 1'b0;
                stop_err_q <= 1'b0;
            end
            case (state)
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) par_q <= par_bad;
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!rx_s) stop_err_q <= 1'b1;
                        // Frame is published and the receiver disarmed so a held-low line cannot retrigger.
                        if (finish) begin
                            data_out   <= shift_q;
                            data_valid <= 1'b1;
                            parity_err <= par_q;
                            frame_err  <= stop_err_q | ~rx_s;
                            armed      <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: 8N1, 8E1 and 8N2 instances driven with directed frames.
module tb_uart_rx_core;

    localparam int BIT = 32;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;
    logic [7:0] d0, d1, d2;
    logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .BAUD_DIV(2)) u_n1 (
        .clk(clk), .reset(reset), .serial_in(ser0), .data_out(d0), .data_valid(dv0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0));

    uart_rx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .BAUD_DIV(2)) u_e1 (
        .clk(clk), .reset(reset), .serial_in(ser1), .data_out(d1), .data_valid(dv1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1));

    uart_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16), .BAUD_DIV(2)) u_n2 (
        .clk(clk), .reset(reset), .serial_in(ser2), .data_out(d2), .data_valid(dv2),
        .parity_err(pe2), .frame_err(fe2), .busy(b2));

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpectedPulse(input string name, input logic [7:0] act);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: unexpected data_valid with data %h, expected no pulse", name, act);
    endtask

    task automatic setLine(input int ln, input logic v);
        case (ln)
            0:       ser0 = v;
            1:       ser1 = v;
            default: ser2 = v;
        endcase
    endtask

    task automatic holdBits(input int ln, input logic v, input int clocks);
        setLine(ln, v);
        repeat (clocks) @(negedge clk);
    endtask

    task automatic pushExpected(input int ln, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        case (ln)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic applyStimulus(input int ln, input logic [7:0] d, input bit has_par, input logic par_bit,
                                 input int nstop, input logic s0, input logic s1,
                                 input logic exp_pe, input logic exp_fe);
        pushExpected(ln, d, exp_pe, exp_fe);
        holdBits(ln, 1'b0, BIT);
        for (int i = 0; i < 8; i++) holdBits(ln, d[i], BIT);
        if (has_par) holdBits(ln, par_bit, BIT);
        holdBits(ln, s0, BIT);
        if (nstop == 2) holdBits(ln, s1, BIT);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dv0 === 1'b1) begin
            if (q0.size() == 0) unexpectedPulse("n1_pulse", d0);
            else begin
                e = q0.pop_front();
                checkOutput("n1_data", d0, e.d);
                checkOutput("n1_parity_err", {7'd0, pe0}, {7'd0, e.pe});
                checkOutput("n1_frame_err", {7'd0, fe0}, {7'd0, e.fe});
                checkOutput("n1_busy_at_valid", {7'd0, b0}, 8'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dv1 === 1'b1) begin
            if (q1.size() == 0) unexpectedPulse("e1_pulse", d1);
            else begin
                e = q1.pop_front();
                checkOutput("e1_data", d1, e.d);
                checkOutput("e1_parity_err", {7'd0, pe1}, {7'd0, e.pe});
                checkOutput("e1_frame_err", {7'd0, fe1}, {7'd0, e.fe});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dv2 === 1'b1) begin
            if (q2.size() == 0) unexpectedPulse("n2_pulse", d2);
            else begin
                e = q2.pop_front();
                checkOutput("n2_data", d2, e.d);
                checkOutput("n2_parity_err", {7'd0, pe2}, {7'd0, e.pe});
                checkOutput("n2_frame_err", {7'd0, fe2}, {7'd0, e.fe});
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out", d0, 8'h00);
        checkOutput("reset_data_valid", {7'd0, dv0}, 8'd0);
        checkOutput("reset_busy", {7'd0, b0}, 8'd0);
        checkOutput("reset_frame_err", {7'd0, fe0}, 8'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 basic frame
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("n1_busy_after_frame", {7'd0, b0}, 8'd0);

        // Short low glitch on an idle line
        holdBits(0, 1'b0, 6);
        checkOutput("glitch_busy_high", {7'd0, b0}, 8'd1);
        holdBits(0, 1'b0, 2);
        holdBits(0, 1'b1, 40);
        checkOutput("glitch_busy_low", {7'd0, b0}, 8'd0);
        checkOutput("glitch_valid_low", {7'd0, dv0}, 8'd0);
        checkOutput("glitch_data_kept", d0, 8'hA5);

        // 8E1: 0x03 has even weight, so parity bit 0 is good and 1 is bad
        applyStimulus(1, 8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(1, 8'h03, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);

        // 8N2 with bad second stop, then break, then a clean frame
        applyStimulus(2, 8'h5A, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        holdBits(2, 1'b0, 3 * BIT);
        checkOutput("n2_busy_during_break", {7'd0, b2}, 8'd0);
        holdBits(2, 1'b1, 2 * BIT);
        applyStimulus(2, 8'h11, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);

        // Back-to-back frames with no idle gap
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);

        // Reset in the middle of data bit 3
        holdBits(0, 1'b0, BIT);
        holdBits(0, 1'b0, BIT);
        holdBits(0, 1'b0, BIT);
        holdBits(0, 1'b1, BIT);
        holdBits(0, 1'b1, BIT / 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midreset_data_out", d0, 8'h00);
        checkOutput("midreset_valid", {7'd0, dv0}, 8'd0);
        checkOutput("midreset_busy", {7'd0, b0}, 8'd0);
        checkOutput("midreset_e1_parity_err", {7'd0, pe1}, 8'd0);
        checkOutput("midreset_n2_data_out", d2, 8'h00);
        setLine(0, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);

        checkOutput("n1_pending", 8'(q0.size()), 8'd0);
        checkOutput("e1_pending", 8'(q1.size()), 8'd0);
        checkOutput("n2_pending", 8'(q2.size()), 8'd0);
        checkOutput("final_busy", {5'd0, b0, b1, b2}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine: synchronises the asynchronous serial line, validates the start bit with a mid-bit re-check, and shifts in a frame of configurable data bits, parity and stop bits using an oversampling tick. Each completed frame is presented as a single-cycle valid pulse with the data and its error flags. It replaces the single-bit start/done controller in the receive path, taking over the bit counting and sampling that controller left to downstream logic, and its `busy` output is the enable for downstream receive-side modules.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `OVERSAMPLE`, default 16: sample ticks per bit; even, at least 4.
- `BAUD_DIV`, default 27: clk cycles per sample tick; at least 1.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `serial_in`  in  1  asynchronous serial line; idles high.
- `data_out`  out  DATA_BITS  last received data, LSB = first bit on the line; reset value 0.
- `data_valid`  out  1  one-cycle pulse when a frame completes; reset value 0.
- `parity_err`  out  1  parity mismatch on the completed frame; valid with `data_valid`, holds until the next frame completes; reset value 0; always 0 when `PARITY` = 0.
- `frame_err`  out  1  a stop bit was sampled low; valid with `data_valid`, holds until the next frame completes; reset value 0.
- `busy`  out  1  high from start detection until the FSM returns to IDLE; reset value 0.

## Operation
- Synchroniser: `serial_in` passes through 2 flops, both reset to 1; the output is `rx_s`. All FSM decisions use `rx_s` only.
- Tick generator: a counter runs 0..BAUD_DIV-1, and `tick` fires when the count equals BAUD_DIV-1.
  - The counter is held at 0 while the FSM is in IDLE.
  - A sample counter counts ticks 0..OVERSAMPLE-1 within each bit.
- Arming: IDLE only accepts a start after `rx_s` has been seen high for at least 1 cycle since reset or since the last frame. A line held low (break) never retriggers.
- FSM states and transitions:
  - IDLE: armed and `rx_s` = 0 → START; sample and tick counters cleared; `busy` goes to 1.
  - START: at tick OVERSAMPLE/2, if `rx_s` = 0 → DATA with both counters restarted; if `rx_s` = 1 → IDLE as a glitch, with no output change.
  - DATA: sample `rx_s` at every OVERSAMPLE-th tick (mid-bit) and shift it in LSB-first. After DATA_BITS samples → PARITY if `PARITY` ≠ 0, otherwise → STOP.
  - PARITY: sample one bit.
    - Odd mode: an error when the XOR of data and parity bit is 0.
    - Even mode: an error when that XOR is 1.
  - STOP: sample STOP_BITS bits; any sample equal to 0 sets the frame error. After the last stop sample, in the next cycle:
    - assert `data_valid` for 1 cycle;
    - update `data_out`, `parity_err` and `frame_err` in that same cycle;
    - go to IDLE, disarmed.
- IDLE re-arms when `rx_s` is 1. A good stop bit therefore allows back-to-back frames with no idle gap.
- A frame with an error still delivers `data_out` and `data_valid`; downstream logic decides whether to discard it.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at their reset values and no `data_valid` pulse. The partial frame is lost.

## Timing
- Input latency: 2 clk cycles from `serial_in` to `rx_s`, plus 1 cycle to leave IDLE.
- Start validation: OVERSAMPLE/2 ticks after the START entry.
- Data bit k (k = 0..DATA_BITS-1) is sampled at tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE after START entry.
- The last stop bit is sampled at tick OVERSAMPLE/2 + (DATA_BITS + P + STOP_BITS)·OVERSAMPLE, with P = 1 if parity is enabled, else 0.
- `data_valid` asserts 1 clk cycle after that sample.
- `busy` deasserts in the same cycle as the `data_valid` pulse.
- One tick = BAUD_DIV clk cycles.

## Test plan
- 8N1, BAUD_DIV = 2, OVERSAMPLE = 16; send 0xA5 → exactly one `data_valid` pulse with `data_out` = 0xA5, `parity_err` = 0, `frame_err` = 0; `busy` low afterwards.
- Low glitch of 4 ticks on an idle line → FSM returns to IDLE; `data_valid` and `busy` end at 0, and `busy` is high only during the glitch window.
- 8E1: send 0x03 with parity bit 0 → `parity_err` = 0. Send 0x03 with parity bit 1 → `parity_err` = 1; `data_out` = 0x03 in both cases.
- 8N2: send 0x5A with the second stop bit low, then hold the line low for 3 bit times, then high → one pulse with `frame_err` = 1 and no second frame during the low hold. A following 0x11 is received cleanly with `frame_err` = 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two pulses, in order 0x00 then 0xFF, with no errors.
- Assert `reset` during data bit 3 of a frame → all outputs 0 with no pulse. The next full frame 0x3C is received correctly.
